// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam int WORD_BYTES   = 4;
  localparam int MEM_BYTES_DEF = 32;
  localparam int WAIT_CYC_DEF  = 1;
  localparam int CNT_W         = 4;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick; priority flips to the other port after each served access.
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       updEn,
  input  logic       updOwner,
  output logic       pick,
  output logic       anyReq
);
  logic prioQ;

  assign anyReq = |req;
  assign pick   = (req[0] && req[1]) ? prioQ : req[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     prioQ <= 1'b0;
    else if (updEn) prioQ <= ~updOwner;
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates two requesters onto a single-port byte memory with word access,
// alignment/range rejection and a programmable number of wait states.
module mem_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int WAIT_CYC  = WAIT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_done_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_done_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - WORD_BYTES);

  state_e state, stateNxt;
  logic pick, anyReq;
  logic selWe, selBad;
  logic [31:0] selAddr, selWdata;
  logic ownerQ, weQ, errHold, memWrQ, memRdQ;
  logic [31:0] addrQ, wdataQ;
  logic [CNT_W-1:0] cnt;
  logic [1:0] gntQ, doneQ, errQ;
  logic [1:0][31:0] rdataQ;

  rr_arbiter_2 uArb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     ({m1_req_i, m0_req_i}),
    .updEn   (state == DONE && !errHold),
    .updOwner(ownerQ),
    .pick    (pick),
    .anyReq  (anyReq)
  );

  assign selWe    = pick ? m1_we_i    : m0_we_i;
  assign selAddr  = pick ? m1_addr_i  : m0_addr_i;
  assign selWdata = pick ? m1_wdata_i : m0_wdata_i;
  assign selBad   = (selAddr[1:0] != 2'b00) || (selAddr > LAST_ADDR);

  // A rejected request spends its gnt cycle in DONE with errHold set, so the
  // done/err pulse lands in the cycle after gnt, like the shortest legal access.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (anyReq) stateNxt = selBad ? DONE : ACCESS;
      ACCESS:  if (cnt == '0) stateNxt = DONE;
      DONE:    if (!errHold) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      ownerQ  <= 1'b0;
      weQ     <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      cnt     <= '0;
      errHold <= 1'b0;
      memWrQ  <= 1'b0;
      memRdQ  <= 1'b0;
      gntQ    <= '0;
      doneQ   <= '0;
      errQ    <= '0;
      rdataQ  <= '0;
    end else begin
      state  <= stateNxt;
      gntQ   <= '0;
      doneQ  <= '0;
      errQ   <= '0;
      memWrQ <= 1'b0;
      case (state)
        IDLE: if (anyReq) begin
          ownerQ     <= pick;
          weQ        <= selWe;
          addrQ      <= selAddr;
          wdataQ     <= selWdata;
          cnt        <= CNT_W'(WAIT_CYC);
          errHold    <= selBad;
          gntQ[pick] <= 1'b1;
          if (!selBad) begin
            memRdQ <= !selWe;
            memWrQ <= selWe && (WAIT_CYC == 0);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            memRdQ        <= 1'b0;
            doneQ[ownerQ] <= 1'b1;
            if (!weQ) rdataQ[ownerQ] <= mem_rdata_i;
          end else begin
            cnt    <= cnt - 1'b1;
            // single write strobe, aligned with the last ACCESS cycle
            memWrQ <= weQ && (cnt == CNT_W'(1));
          end
        end
        DONE: if (errHold) begin
          errHold       <= 1'b0;
          doneQ[ownerQ] <= 1'b1;
          errQ[ownerQ]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt_o    = gntQ[0];
  assign m1_gnt_o    = gntQ[1];
  assign m0_done_o   = doneQ[0];
  assign m1_done_o   = doneQ[1];
  assign m0_err_o    = errQ[0];
  assign m1_err_o    = errQ[1];
  assign m0_rdata_o  = rdataQ[0];
  assign m1_rdata_o  = rdataQ[1];
  assign mem_addr_o  = addrQ;
  assign mem_wdata_o = wdataQ;
  assign mem_write_o = memWrQ;
  assign mem_read_o  = memRdQ;
  assign busy_o      = (state != IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: three arbiters (wait states 1, 3, 0), each with its own byte memory model.
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic memInit, clrMon;
  logic rst [3];
  logic req0 [3], we0 [3], req1 [3], we1 [3];
  logic [31:0] addr0 [3], wdata0 [3], addr1 [3], wdata1 [3];
  logic gnt0 [3], done0 [3], err0 [3], gnt1 [3], done1 [3], err1 [3];
  logic [31:0] rdata0 [3], rdata1 [3];
  logic [31:0] memAddr [3], memWdata [3], memRdata [3];
  logic memWr [3], memRd [3], busy [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [7:0] mem [32];
    logic [4:0] ra;
    int wrCnt;
    logic rdSeen;

    mem_access_arbiter #(.MEM_BYTES(32), .WAIT_CYC((g == 0) ? 1 : (g == 1) ? 3 : 0)) dut (
      .clk_i(clk), .rst_i(rst[g]),
      .m0_req_i(req0[g]), .m0_we_i(we0[g]), .m0_addr_i(addr0[g]), .m0_wdata_i(wdata0[g]),
      .m0_gnt_o(gnt0[g]), .m0_done_o(done0[g]), .m0_err_o(err0[g]), .m0_rdata_o(rdata0[g]),
      .m1_req_i(req1[g]), .m1_we_i(we1[g]), .m1_addr_i(addr1[g]), .m1_wdata_i(wdata1[g]),
      .m1_gnt_o(gnt1[g]), .m1_done_o(done1[g]), .m1_err_o(err1[g]), .m1_rdata_o(rdata1[g]),
      .mem_addr_o(memAddr[g]), .mem_wdata_o(memWdata[g]), .mem_write_o(memWr[g]),
      .mem_read_o(memRd[g]), .mem_rdata_i(memRdata[g]), .busy_o(busy[g])
    );

    assign ra = memAddr[g][4:0];
    assign memRdata[g] = {mem[ra + 5'd3], mem[ra + 5'd2], mem[ra + 5'd1], mem[ra]};

    // preload pattern: byte i holds 0x40 + i
    always @(posedge clk) begin
      if (memInit) begin
        for (int j = 0; j < 32; j++) mem[j] <= 8'(8'h40 + j);
      end else if (memWr[g]) begin
        mem[ra]        <= memWdata[g][7:0];
        mem[ra + 5'd1] <= memWdata[g][15:8];
        mem[ra + 5'd2] <= memWdata[g][23:16];
        mem[ra + 5'd3] <= memWdata[g][31:24];
      end
    end

    always @(negedge clk) begin
      if (clrMon) begin
        wrCnt  <= 0;
        rdSeen <= 1'b0;
      end else begin
        wrCnt  <= wrCnt + 32'(memWr[g]);
        rdSeen <= rdSeen | memRd[g] | memWr[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    if (p == 0) begin
      req0[i] = 1'b1; we0[i] = w; addr0[i] = a; wdata0[i] = d;
    end else begin
      req1[i] = 1'b1; we1[i] = w; addr1[i] = a; wdata1[i] = d;
    end
  endtask

  initial begin
    memInit = 1'b1;
    clrMon  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = '0; wdata0[i] = '0;
      req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = '0; wdata1[i] = '0;
    end
    repeat (3) tick();
    chk("rst_gnt0", 32'(gnt0[0]), 0);
    chk("rst_done0", 32'(done0[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_memwr", 32'(memWr[0]), 0);
    chk("rst_memrd", 32'(memRd[0]), 0);
    chk("rst_memaddr", memAddr[0], 0);
    chk("rst_rdata1", rdata1[0], 0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    memInit = 1'b0;
    clrMon  = 1'b0;
    tick();

    // 1: m0 write then m1 read of the same word
    setReq(0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("t1_gnt0", 32'(gnt0[0]), 1);
    chk("t1_wr_early", 32'(memWr[0]), 0);
    req0[0] = 1'b0;
    tick();
    chk("t1_wr_final", 32'(memWr[0]), 1);
    tick();
    chk("t1_done0", 32'(done0[0]), 1);
    chk("t1_err0", 32'(err0[0]), 0);
    chk("t1_wr_off", 32'(memWr[0]), 0);
    tick();
    chk("t1_idle", 32'(busy[0]), 0);
    chk("t1_mem", {g_inst[0].mem[19], g_inst[0].mem[18], g_inst[0].mem[17], g_inst[0].mem[16]},
        32'hDEADBEEF);
    chk("t1_wrcnt", 32'(g_inst[0].wrCnt), 1);
    setReq(0, 1, 1'b0, 32'h10, 0);
    tick();
    chk("t1_gnt1", 32'(gnt1[0]), 1);
    chk("t1_rd", 32'(memRd[0]), 1);
    req1[0] = 1'b0;
    tick();
    chk("t1_rd2", 32'(memRd[0]), 1);
    tick();
    chk("t1_done1", 32'(done1[0]), 1);
    chk("t1_err1", 32'(err1[0]), 0);
    chk("t1_rdata1", rdata1[0], 32'hDEADBEEF);
    chk("t1_rdata0", rdata0[0], 0);
    tick();

    // 2: both requesters held from reset
    rst[0] = 1'b0;
    setReq(0, 0, 1'b0, 32'h00, 0);
    setReq(0, 1, 1'b0, 32'h04, 0);
    tick();
    rst[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        req0[0] = 1'b0;
        req1[0] = 1'b0;
      end
      tick();
      chk($sformatf("t2_gnt0_c%0d", i), 32'(gnt0[0]), 32'((i == 1) || (i == 9)));
      chk($sformatf("t2_gnt1_c%0d", i), 32'(gnt1[0]), 32'((i == 5) || (i == 13)));
    end
    chk("t2_rdata0", rdata0[0], 32'h43424140);
    chk("t2_rdata1", rdata1[0], 32'h47464544);
    tick();
    chk("t2_idle", 32'(busy[0]), 0);

    // 3: misaligned and out-of-range rejected, top word accepted
    clrMon = 1'b1;
    tick();
    clrMon = 1'b0;
    setReq(0, 0, 1'b0, 32'h02, 0);
    tick();
    chk("t3_gnt0", 32'(gnt0[0]), 1);
    chk("t3_done_early", 32'(done0[0]), 0);
    req0[0] = 1'b0;
    tick();
    chk("t3_done0", 32'(done0[0]), 1);
    chk("t3_err0", 32'(err0[0]), 1);
    chk("t3_rdata0_kept", rdata0[0], 32'h43424140);
    tick();
    chk("t3_idle0", 32'(busy[0]), 0);
    setReq(0, 1, 1'b0, 32'h20, 0);
    tick();
    chk("t3_gnt1", 32'(gnt1[0]), 1);
    req1[0] = 1'b0;
    tick();
    chk("t3_done1", 32'(done1[0]), 1);
    chk("t3_err1", 32'(err1[0]), 1);
    tick();
    chk("t3_no_strobe", 32'(g_inst[0].rdSeen), 0);
    setReq(0, 0, 1'b0, 32'h1C, 0);
    tick();
    req0[0] = 1'b0;
    tick();
    tick();
    chk("t3_top_done", 32'(done0[0]), 1);
    chk("t3_top_err", 32'(err0[0]), 0);
    chk("t3_top_data", rdata0[0], 32'h5F5E5D5C);
    tick();

    // 6: m1 request arrives while m0 is in ACCESS
    setReq(0, 0, 1'b0, 32'h10, 0);
    tick();
    chk("t6_gnt0", 32'(gnt0[0]), 1);
    req0[0] = 1'b0;
    setReq(0, 1, 1'b0, 32'h1C, 0);
    tick();
    chk("t6_gnt1_c2", 32'(gnt1[0]), 0);
    tick();
    chk("t6_done0", 32'(done0[0]), 1);
    chk("t6_gnt1_c3", 32'(gnt1[0]), 0);
    chk("t6_rdata0", rdata0[0], 32'hDEADBEEF);
    tick();
    chk("t6_gnt1_c4", 32'(gnt1[0]), 0);
    chk("t6_idle", 32'(busy[0]), 0);
    tick();
    chk("t6_gnt1_c5", 32'(gnt1[0]), 1);
    req1[0] = 1'b0;
    tick();
    tick();
    chk("t6_done1", 32'(done1[0]), 1);
    chk("t6_rdata1", rdata1[0], 32'h5F5E5D5C);
    chk("t6_rdata0_held", rdata0[0], 32'hDEADBEEF);

    // 4: reset in the middle of a 3-wait-state write
    setReq(1, 0, 1'b1, 32'h08, 32'h12345678);
    tick();
    chk("t4_gnt0", 32'(gnt0[1]), 1);
    req0[1] = 1'b0;
    tick();
    chk("t4_busy_pre", 32'(busy[1]), 1);
    rst[1] = 1'b0;
    #1;
    chk("t4_busy_rst", 32'(busy[1]), 0);
    chk("t4_addr_rst", memAddr[1], 0);
    chk("t4_wdata_rst", memWdata[1], 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_nodone_%0d", i), 32'(done0[1]), 0);
      chk($sformatf("t4_nowr_%0d", i), 32'(memWr[1]), 0);
    end
    rst[1] = 1'b1;
    chk("t4_mem", {g_inst[1].mem[11], g_inst[1].mem[10], g_inst[1].mem[9], g_inst[1].mem[8]},
        32'h4B4A4948);
    chk("t4_wrcnt", 32'(g_inst[1].wrCnt), 0);
    setReq(1, 1, 1'b0, 32'h08, 0);
    tick();
    chk("t4_gnt1", 32'(gnt1[1]), 1);
    req1[1] = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("t4_done1_c%0d", i), 32'(done1[1]), 0);
    end
    tick();
    chk("t4_done1", 32'(done1[1]), 1);
    chk("t4_rdata1", rdata1[1], 32'h4B4A4948);
    chk("t4_done0", 32'(done0[1]), 0);

    // 5: zero wait states, back-to-back reads
    setReq(2, 0, 1'b0, 32'h00, 0);
    tick();
    chk("t5_gnt_a", 32'(gnt0[2]), 1);
    req0[2] = 1'b0;
    tick();
    chk("t5_done_a", 32'(done0[2]), 1);
    chk("t5_data_a", rdata0[2], 32'h43424140);
    setReq(2, 0, 1'b0, 32'h04, 0);
    tick();
    chk("t5_gap1", 32'(done0[2]), 0);
    tick();
    chk("t5_gnt_b", 32'(gnt0[2]), 1);
    chk("t5_gap2", 32'(done0[2]), 0);
    req0[2] = 1'b0;
    tick();
    chk("t5_done_b", 32'(done0[2]), 1);
    chk("t5_data_b", rdata0[2], 32'h47464544);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
